// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
//
// Instruction-fetch stage and IF/ID pipeline register of the five-stage MIPS
// core. Owns the program counter, drives the instruction-memory address,
// chooses the next PC (sequential, ID-stage J/JR, EX-stage branch redirect)
// and hands the fetched word plus its PC+4 to Decode.
//
// Optional feature macro: IF_PERF_CNT_EN
//   defined   -> fetch_count / bubble_count are live wrapping 32-bit counters
//   undefined -> both outputs are tied to zero and no counter flops exist
// ---------------------------------------------------------------------------
module if_stage #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        ex_branch_taken,
   input  logic [31:0] ex_branch_target,
   input  logic        id_j,
   input  logic        id_jr,
   input  logic [31:0] id_jr_target,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic [31:0] IF_ID_Instruction,
   output logic [31:0] IF_ID_PC4,
   output logic        IF_ID_valid,
   output logic [31:0] fetch_count,
   output logic [31:0] bubble_count
);

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic        r_imemReq;
   logic [31:0] r_ifidInstr;
   logic [31:0] r_ifidPc4;
   logic        r_ifidValid;

   logic [31:0] w_pcPlus4;
   logic [31:0] w_jTarget;
   logic [31:0] w_jrTarget;
   logic [31:0] w_brTarget;
   logic [31:0] w_pcNext;
   logic        w_doFetch;
   logic        w_runBubble;
   logic        w_bootBubble;
   logic        w_writeBubble;
   logic        w_unused;

   // Redirect targets are word aligned; the low two bits of the incoming
   // addresses are dropped on purpose.
   assign w_pcPlus4  = r_pc + 32'd4;
   assign w_jTarget  = {r_ifidPc4[31:28], r_ifidInstr[25:0], 2'b00};
   assign w_jrTarget = {id_jr_target[31:2], 2'b00};
   assign w_brTarget = {ex_branch_target[31:2], 2'b00};
   assign w_unused   = ^{ex_branch_target[1:0], id_jr_target[1:0]};

   // Next-PC selection and IF/ID action for this edge. The if/else chain
   // encodes the redirect priority: EX branch beats everything (even a
   // stall), then the hazard-unit stall, then ID-stage jumps (only when the
   // jump really sits in IF/ID), then a memory miss, else a normal fetch.
   always_comb begin
      w_pcNext     = r_pc;
      w_doFetch    = 1'b0;
      w_runBubble  = 1'b0;
      w_bootBubble = 1'b0;
      if (r_state == BOOT) begin
         w_bootBubble = 1'b1;
      end else if (ex_branch_taken) begin
         w_pcNext    = w_brTarget;
         w_runBubble = 1'b1;
      end else if (stall) begin
         w_pcNext = r_pc;
      end else if (id_j && r_ifidValid) begin
         w_pcNext    = w_jTarget;
         w_runBubble = 1'b1;
      end else if (id_jr && r_ifidValid) begin
         w_pcNext    = w_jrTarget;
         w_runBubble = 1'b1;
      end else if (!imem_valid) begin
         w_pcNext    = r_pc;
         w_runBubble = 1'b1;
      end else begin
         w_pcNext  = w_pcPlus4;
         w_doFetch = 1'b1;
      end
   end

   assign w_writeBubble = w_bootBubble | w_runBubble;

   // Boot/run state machine with the PC and the IF/ID register. Reset wins
   // over every other input, so a redirect arriving with reset is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= BOOT;
         r_imemReq   <= 1'b0;
         r_pc        <= PC_RESET;
         r_ifidInstr <= 32'h0;
         r_ifidPc4   <= 32'h0;
         r_ifidValid <= 1'b0;
      end else begin
         case (r_state)
            BOOT: begin
               r_state   <= RUN;
               r_imemReq <= 1'b1;
            end
            RUN: begin
               r_state   <= RUN;
               r_imemReq <= 1'b1;
            end
            default: begin
               r_state   <= BOOT;
               r_imemReq <= 1'b0;
            end
         endcase
         r_pc <= w_pcNext;
         if (w_writeBubble) begin
            r_ifidInstr <= 32'h0;
            r_ifidPc4   <= 32'h0;
            r_ifidValid <= 1'b0;
         end else if (w_doFetch) begin
            r_ifidInstr <= imem_rdata;
            r_ifidPc4   <= w_pcPlus4;
            r_ifidValid <= 1'b1;
         end
      end
   end

   assign imem_req          = r_imemReq;
   assign imem_addr         = r_pc;
   assign IF_ID_Instruction = r_ifidInstr;
   assign IF_ID_PC4         = r_ifidPc4;
   assign IF_ID_valid       = r_ifidValid;

`ifdef IF_PERF_CNT_EN
   logic [31:0] r_fetchCount;
   logic [31:0] r_bubbleCount;

   // Performance counters: accepted instructions and bubbles written while
   // running. Stall cycles count as neither; both wrap naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetchCount  <= 32'h0;
         r_bubbleCount <= 32'h0;
      end else begin
         if (w_doFetch) begin
            r_fetchCount <= r_fetchCount + 32'd1;
         end
         if (w_runBubble) begin
            r_bubbleCount <= r_bubbleCount + 32'd1;
         end
      end
   end

   assign fetch_count  = r_fetchCount;
   assign bubble_count = r_bubbleCount;
`else
   assign fetch_count  = 32'h0;
   assign bubble_count = 32'h0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
//
// Self-checking bench for if_stage. Each cycle the bench drives one set of
// inputs, advances a behavioural model of the fetch stage by the redirect
// rules, and compares every DUT output against the model on the falling edge.
// Directed sequences from the bring-up scenarios come first, followed by a
// long randomized run with occasional mid-operation resets.
// ---------------------------------------------------------------------------
module tb_if_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        ex_branch_taken;
   logic [31:0] ex_branch_target;
   logic        id_j;
   logic        id_jr;
   logic [31:0] id_jr_target;
   logic        imem_valid;
   logic [31:0] imem_rdata;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] IF_ID_Instruction;
   logic [31:0] IF_ID_PC4;
   logic        IF_ID_valid;
   logic [31:0] fetch_count;
   logic [31:0] bubble_count;

   int errors = 0;
   int checks = 0;

   // Model state: the architectural view of the stage.
   bit          mRunning;
   logic [31:0] mPc;
   logic [31:0] mInstr;
   logic [31:0] mPc4;
   bit          mValid;
   logic [31:0] mFetches;
   logic [31:0] mBubbles;

   if_stage #(
      .PC_RESET(RESET_PC)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .stall            (stall),
      .ex_branch_taken  (ex_branch_taken),
      .ex_branch_target (ex_branch_target),
      .id_j             (id_j),
      .id_jr            (id_jr),
      .id_jr_target     (id_jr_target),
      .imem_valid       (imem_valid),
      .imem_rdata       (imem_rdata),
      .imem_req         (imem_req),
      .imem_addr        (imem_addr),
      .IF_ID_Instruction(IF_ID_Instruction),
      .IF_ID_PC4        (IF_ID_PC4),
      .IF_ID_valid      (IF_ID_valid),
      .fetch_count      (fetch_count),
      .bubble_count     (bubble_count)
   );

   // Free-running core clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Contents of instruction memory: a scrambled function of the address,
   // with a J instruction planted at 0x1000_0004.
   function automatic logic [31:0] memWord(input logic [31:0] addr);
      if (addr == 32'h1000_0004) return 32'h0800_0040;
      return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".imem_req"}, {31'h0, imem_req}, {31'h0, mRunning});
      checkOutput({tag, ".imem_addr"}, imem_addr, mPc);
      checkOutput({tag, ".instr"}, IF_ID_Instruction, mInstr);
      checkOutput({tag, ".pc4"}, IF_ID_PC4, mPc4);
      checkOutput({tag, ".valid"}, {31'h0, IF_ID_valid}, {31'h0, mValid});
`ifdef IF_PERF_CNT_EN
      checkOutput({tag, ".fetch_count"}, fetch_count, mFetches);
      checkOutput({tag, ".bubble_count"}, bubble_count, mBubbles);
`else
      checkOutput({tag, ".fetch_count"}, fetch_count, 32'h0);
      checkOutput({tag, ".bubble_count"}, bubble_count, 32'h0);
`endif
   endtask

   // Drive one cycle of inputs (memory answers for the model's PC), let the
   // clock edge happen, then advance the model by the same rules.
   task automatic applyStimulus(input bit rst, input bit stl, input bit br,
                                input logic [31:0] brTgt, input bit j,
                                input bit jr, input logic [31:0] jrTgt,
                                input bit iv);
      logic [31:0] word;
      word             = memWord(mPc);
      reset            = rst;
      stall            = stl;
      ex_branch_taken  = br;
      ex_branch_target = brTgt;
      id_j             = j;
      id_jr            = jr;
      id_jr_target     = jrTgt;
      imem_valid       = iv;
      imem_rdata       = iv ? word : 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      if (rst) begin
         mRunning = 1'b0;
         mPc      = RESET_PC;
         mInstr   = 32'h0;
         mPc4     = 32'h0;
         mValid   = 1'b0;
         mFetches = 32'h0;
         mBubbles = 32'h0;
      end else if (!mRunning) begin
         mRunning = 1'b1;
         mInstr   = 32'h0;
         mPc4     = 32'h0;
         mValid   = 1'b0;
      end else if (br || (!stl && ((j || jr) && mValid)) || (!stl && !iv)) begin
         if (br)
            mPc = brTgt & 32'hFFFF_FFFC;
         else if (j && mValid)
            mPc = (mPc4 & 32'hF000_0000) | ((mInstr & 32'h03FF_FFFF) << 2);
         else if (jr && mValid)
            mPc = jrTgt & 32'hFFFF_FFFC;
         mInstr   = 32'h0;
         mPc4     = 32'h0;
         mValid   = 1'b0;
         mBubbles = mBubbles + 1;
      end else if (!stl) begin
         mInstr   = word;
         mPc4     = mPc + 4;
         mValid   = 1'b1;
         mPc      = mPc + 4;
         mFetches = mFetches + 1;
      end
      @(negedge clk);
   endtask

   task automatic plainStep(input string tag, input bit iv);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, iv);
      checkAll(tag);
   endtask

   initial begin
      mRunning = 1'b0;
      mPc      = 32'h0;
      mInstr   = 32'h0;
      mPc4     = 32'h0;
      mValid   = 1'b0;
      mFetches = 32'h0;
      mBubbles = 32'h0;
      @(negedge clk);

      // Reset, boot cycle, then sequential fetch from the reset vector.
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
      checkAll("reset");
      checkOutput("reset.addr_is_vector", imem_addr, 32'h0000_3000);
      plainStep("boot", 1'b1);
      checkOutput("boot.req_up", {31'h0, imem_req}, 32'h1);
      plainStep("seq0", 1'b1);
      checkOutput("seq0.pc4", IF_ID_PC4, 32'h0000_3004);
      plainStep("seq1", 1'b1);
      checkOutput("seq1.addr", imem_addr, 32'h0000_3008);

      // Stall for three cycles at PC 0x10, then release.
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0, 1'b1);
      checkAll("toPc10");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
         checkAll("stall");
      end
      plainStep("stallRelease", 1'b1);
      checkOutput("stallRelease.addr", imem_addr, 32'h0000_0014);

      // J in IF/ID with PC4 0x1000_0008 redirects to 0x1000_0100.
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h1000_0004, 1'b0, 1'b0, 32'h0, 1'b1);
      plainStep("fetchJ", 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
      checkAll("jump");
      checkOutput("jump.addr", imem_addr, 32'h1000_0100);

      // Branch together with stall and JR: branch wins.
      plainStep("preBr", 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0203, 1'b0, 1'b1, 32'h0000_0800, 1'b1);
      checkAll("brStallJr");
      checkOutput("brStallJr.addr", imem_addr, 32'h0000_0200);

      // Memory not ready for two cycles at PC 0x40.
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0, 1'b1);
      plainStep("miss0", 1'b0);
      plainStep("miss1", 1'b0);
      checkOutput("miss.addr", imem_addr, 32'h0000_0040);
      plainStep("missDone", 1'b1);

      // Stall with memory not ready: plain hold, no bubble.
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      checkAll("stallMiss");

      // Fetch at the top of the address space wraps to zero.
      applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b1);
      plainStep("wrap", 1'b1);
      checkOutput("wrap.addr", imem_addr, 32'h0);
      checkOutput("wrap.pc4", IF_ID_PC4, 32'h0);

      // Reset while stalled returns everything to reset values.
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0500, 1'b0, 1'b0, 32'h0, 1'b1);
      checkAll("midReset");
      checkOutput("midReset.addr", imem_addr, 32'h0000_3000);

      // Randomized run against the model.
      for (int i = 0; i < 3000; i++) begin
         bit          rst;
         bit          stl;
         bit          br;
         bit          j;
         bit          jr;
         bit          iv;
         logic [31:0] brTgt;
         logic [31:0] jrTgt;
         rst   = ($urandom_range(0, 99) < 2);
         stl   = ($urandom_range(0, 99) < 20);
         br    = ($urandom_range(0, 99) < 10);
         j     = ($urandom_range(0, 99) < 12);
         jr    = ($urandom_range(0, 99) < 12);
         iv    = ($urandom_range(0, 99) < 80);
         brTgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                              : 32'($urandom);
         jrTgt = 32'($urandom);
         applyStimulus(rst, stl, br, brTgt, j, jr, jrTgt, iv);
         checkAll("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
